// File: rtl/tlb_xlate_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module : tlb_xlate_pipe_pkg
// Brief  : Shared page-type encoding and NAPOT constants for TLB PA formation.
// Rev    : 1.0
// ============================================================================
package tlb_xlate_pipe_pkg;

  typedef enum logic [2:0] {
    KILO = 3'd0,
    MEGA = 3'd1,
    GIGA = 3'd2,
    TERA = 3'd3,
    PETA = 3'd4
  } pagetype_t;

  // A 64 KiB NAPOT page takes its low four PPN bits from the VPN
  localparam int NAPOT_MASK_BITS = 4;

endpackage
`default_nettype wire

// File: rtl/tlb_xlate_pipe_pgmask.sv
`default_nettype none
// ============================================================================
// Module : tlb_pgmask
// Brief  : Page-type/NAPOT to VPN-substitution mask, with illegal-type flag.
// Rev    : 1.0
// ============================================================================
module tlb_pgmask
  import tlb_xlate_pipe_pkg::*;
#(
  parameter int MASK_BITS  = 44,
  parameter int LEVELS     = 4,
  parameter int LEVEL_BITS = 9,
  parameter int NAPOT_EN   = 1
) (
  input  logic [2:0]           page_type_i,
  input  logic                 napot_i,
  output logic [MASK_BITS-1:0] mask_o,
  output logic                 illegal_o
);

  logic        w_napot_sel;
  logic [31:0] w_span;

  assign illegal_o   = (page_type_i >= 3'(LEVELS));
  assign w_napot_sel = (NAPOT_EN != 0) && napot_i && (page_type_i == KILO);
  assign w_span      = 32'(page_type_i) * 32'(LEVEL_BITS);

  always_comb begin
    mask_o = '0;
    if (illegal_o) begin
      mask_o = '0;
    end else if (w_napot_sel) begin
      mask_o = MASK_BITS'({NAPOT_MASK_BITS{1'b1}});
    end else begin
      for (int i = 0; i < MASK_BITS; i++) begin
        mask_o[i] = (32'(i) < w_span);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tlb_xlate_pipe.sv
`default_nettype none
// ============================================================================
// Module : tlb_xlate_pipe
// Brief  : Two-stage TLB PA formation (PPN/VPN merge per page level) with
//          valid/ready on both sides, backpressure and flush.
// Rev    : 1.0
// ============================================================================
module tlb_xlate_pipe
  import tlb_xlate_pipe_pkg::*;
#(
  parameter int VPN_BITS   = 36,
  parameter int PPN_BITS   = 44,
  parameter int PA_BITS    = 56,
  parameter int LEVELS     = 4,
  parameter int LEVEL_BITS = 9,
  parameter int NAPOT_EN   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Flush,
  input  logic                ReqValid,
  output logic                ReqReady,
  input  logic [VPN_BITS-1:0] VPN,
  input  logic [PPN_BITS-1:0] PPN,
  input  logic [2:0]          HitPageType,
  input  logic                Napot,
  input  logic [11:0]         Offset,
  input  logic                TLBHit,
  output logic                RspValid,
  input  logic                RspReady,
  output logic [PA_BITS-1:0]  TLBPAdr,
  output logic                Miss,
  output logic                Misaligned
);

  logic                w_mask_illegal;
  logic [PPN_BITS-1:0] w_mask;
  logic                w_s2_load;
  logic                w_accept;
  logic                s1_v_d, s2_v_d;
  logic [PPN_BITS-1:0] w_mixed;
  logic [PA_BITS-1:0]  w_pa_d;
  logic                w_mis_d;

  logic                s1_v_q, s2_v_q;
  logic [VPN_BITS-1:0] s1_vpn_q;
  logic [PPN_BITS-1:0] s1_ppn_q;
  logic [PPN_BITS-1:0] s1_mask_q;
  logic [11:0]         s1_off_q;
  logic                s1_hit_q;
  logic                s1_illegal_q;
  logic [PA_BITS-1:0]  s2_pa_q;
  logic                s2_miss_q;
  logic                s2_mis_q;

  tlb_pgmask #(
    .MASK_BITS  (PPN_BITS),
    .LEVELS     (LEVELS),
    .LEVEL_BITS (LEVEL_BITS),
    .NAPOT_EN   (NAPOT_EN)
  ) u_pgmask (
    .page_type_i (HitPageType),
    .napot_i     (Napot),
    .mask_o      (w_mask),
    .illegal_o   (w_mask_illegal)
  );

  assign w_s2_load = !s2_v_q || RspReady;
  assign ReqReady  = !reset && !Flush && (!s1_v_q || w_s2_load);
  assign w_accept  = ReqValid && ReqReady;

  always_comb begin
    s1_v_d = s1_v_q;
    s2_v_d = s2_v_q;
    if (w_s2_load) begin
      s2_v_d = s1_v_q;
      s1_v_d = 1'b0;
    end
    if (w_accept) s1_v_d = 1'b1;
    if (Flush) begin
      s1_v_d = 1'b0;
      s2_v_d = 1'b0;
    end
  end

  // Masked bits are replaced, so a misaligned PPN cannot leak into the PA
  assign w_mixed = (s1_ppn_q & ~s1_mask_q) | (PPN_BITS'(s1_vpn_q) & s1_mask_q);
  assign w_pa_d  = s1_hit_q ? {w_mixed, s1_off_q} : '0;
  assign w_mis_d = s1_hit_q && (s1_illegal_q || (|(s1_ppn_q & s1_mask_q)));

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v_q       <= 1'b0;
      s2_v_q       <= 1'b0;
      s1_vpn_q     <= '0;
      s1_ppn_q     <= '0;
      s1_mask_q    <= '0;
      s1_off_q     <= '0;
      s1_hit_q     <= 1'b0;
      s1_illegal_q <= 1'b0;
      s2_pa_q      <= '0;
      s2_miss_q    <= 1'b0;
      s2_mis_q     <= 1'b0;
    end else begin
      s1_v_q <= s1_v_d;
      s2_v_q <= s2_v_d;
      if (w_accept) begin
        s1_vpn_q     <= VPN;
        s1_ppn_q     <= PPN;
        s1_mask_q    <= w_mask;
        s1_off_q     <= Offset;
        s1_hit_q     <= TLBHit;
        s1_illegal_q <= w_mask_illegal;
      end
      if (w_s2_load && s1_v_q) begin
        s2_pa_q   <= w_pa_d;
        s2_miss_q <= !s1_hit_q;
        s2_mis_q  <= w_mis_d;
      end
    end
  end

  assign RspValid   = s2_v_q;
  assign TLBPAdr    = s2_pa_q;
  assign Miss       = s2_miss_q;
  assign Misaligned = s2_mis_q;

endmodule
`default_nettype wire

// File: tb/tb_tlb_xlate_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_tlb_xlate_pipe
// Brief  : Self-checking bench: directed vector table, randomized scoreboard
//          against an arithmetic page model, backpressure/flush/reset cases.
// Rev    : 1.0
// ============================================================================
module tb_tlb_xlate_pipe;

  localparam int VB = 36;
  localparam int PB = 44;
  localparam int AB = 56;
  localparam int LV = 4;
  localparam int LB = 9;

  logic          clk = 1'b0;
  logic          reset, Flush, ReqValid, RspReady, TLBHit, Napot;
  logic [VB-1:0] VPN;
  logic [PB-1:0] PPN;
  logic [2:0]    HitPageType;
  logic [11:0]   Offset;
  logic          ReqReady, RspValid, Miss, Misaligned;
  logic [AB-1:0] TLBPAdr;
  logic          nReqReady, nRspValid, nMiss, nMis;
  logic [AB-1:0] nPAdr;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [AB-1:0] pa;
    logic          miss;
    logic          mis;
  } exp_t;

  typedef struct packed {
    logic [VB-1:0] vpn;
    logic [PB-1:0] ppn;
    logic [2:0]    t;
    logic          napot;
    logic          hit;
    logic [AB-1:0] pa;
    logic          miss;
    logic          mis;
    logic [AB-1:0] pa_nn;
  } vec_t;

  exp_t          q[$];
  exp_t          qn[$];
  exp_t          pend, pend_n;
  vec_t          vecs[12];
  bit            acc;
  bit            stall_prev = 1'b0;
  logic [AB-1:0] hold_pa;
  logic [1:0]    hold_fl;

  always #5 clk = ~clk;

  tlb_xlate_pipe #(.VPN_BITS(VB), .PPN_BITS(PB), .PA_BITS(AB), .LEVELS(LV),
                   .LEVEL_BITS(LB), .NAPOT_EN(1)) dut (
    .clk(clk), .reset(reset), .Flush(Flush), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .VPN(VPN), .PPN(PPN), .HitPageType(HitPageType), .Napot(Napot), .Offset(Offset),
    .TLBHit(TLBHit), .RspValid(RspValid), .RspReady(RspReady), .TLBPAdr(TLBPAdr),
    .Miss(Miss), .Misaligned(Misaligned));

  tlb_xlate_pipe #(.VPN_BITS(VB), .PPN_BITS(PB), .PA_BITS(AB), .LEVELS(LV),
                   .LEVEL_BITS(LB), .NAPOT_EN(0)) dut_nn (
    .clk(clk), .reset(reset), .Flush(Flush), .ReqValid(ReqValid), .ReqReady(nReqReady),
    .VPN(VPN), .PPN(PPN), .HitPageType(HitPageType), .Napot(Napot), .Offset(Offset),
    .TLBHit(TLBHit), .RspValid(nRspValid), .RspReady(RspReady), .TLBPAdr(nPAdr),
    .Miss(nMiss), .Misaligned(nMis));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  // Page of 2^k VPN-sourced pages: upper PPN kept, low k bits from VPN.
  function automatic exp_t ref_model(input logic [VB-1:0] vpn, input logic [PB-1:0] ppn,
                                     input int t, input bit napot, input bit hit,
                                     input logic [11:0] off, input bit nen);
    exp_t e;
    longint unsigned span, page, p, v;
    int k;
    if (t >= LV) k = 0;
    else if (t == 0 && napot && nen) k = 4;
    else k = t * LB;
    p = 64'(ppn);
    v = 64'(vpn);
    span = 64'd1 << k;
    page = (p / span) * span + (v % span);
    e.miss = !hit;
    e.pa   = hit ? AB'(page * 4096 + 64'(off)) : '0;
    e.mis  = hit && ((t >= LV) || ((p % span) != 0));
    return e;
  endfunction

  function automatic vec_t mkv(input logic [VB-1:0] vpn, input logic [PB-1:0] ppn,
                               input logic [2:0] t, input logic napot, input logic hit,
                               input logic [AB-1:0] pa, input logic miss, input logic mis,
                               input logic [AB-1:0] pa_nn);
    vec_t v;
    v.vpn = vpn; v.ppn = ppn; v.t = t; v.napot = napot; v.hit = hit;
    v.pa = pa; v.miss = miss; v.mis = mis; v.pa_nn = pa_nn;
    return v;
  endfunction

  task automatic drive_req(input logic [VB-1:0] vpn, input logic [PB-1:0] ppn,
                           input logic [2:0] t, input logic napot, input logic hit,
                           input logic [11:0] off);
    VPN = vpn; PPN = ppn; HitPageType = t; Napot = napot; TLBHit = hit; Offset = off;
    pend   = ref_model(vpn, ppn, int'(t), napot, hit, off, 1'b1);
    pend_n = ref_model(vpn, ppn, int'(t), napot, hit, off, 1'b0);
  endtask

  // One clock: inspect handshakes before the edge, then advance to the next negedge.
  task automatic step(output bit a);
    exp_t e;
    bit   flushing;
    #1;
    flushing = Flush || reset;
    a = ReqValid && ReqReady;
    if (stall_prev) begin
      chk("stall_valid", 64'(RspValid), 64'd1);
      chk("stall_pa", 64'(TLBPAdr), 64'(hold_pa));
      chk("stall_flags", 64'({Miss, Misaligned}), 64'(hold_fl));
    end
    if (RspValid && RspReady) begin
      if (q.size() == 0) chk("spurious_rsp", 64'd1, 64'd0);
      else begin
        e = q.pop_front();
        chk("rsp_pa", 64'(TLBPAdr), 64'(e.pa));
        chk("rsp_miss", 64'(Miss), 64'(e.miss));
        chk("rsp_misaligned", 64'(Misaligned), 64'(e.mis));
      end
    end
    if (nRspValid && RspReady) begin
      if (qn.size() == 0) chk("spurious_rsp_nonapot", 64'd1, 64'd0);
      else begin
        e = qn.pop_front();
        chk("rsp_pa_nonapot", 64'(nPAdr), 64'(e.pa));
      end
    end
    stall_prev = RspValid && !RspReady && !flushing;
    hold_pa = TLBPAdr;
    hold_fl = {Miss, Misaligned};
    if (a) begin
      q.push_back(pend);
      qn.push_back(pend_n);
    end
    @(posedge clk);
    @(negedge clk);
    if (flushing) begin
      q.delete();
      qn.delete();
    end
  endtask

  task automatic drain();
    bit a;
    ReqValid = 1'b0;
    RspReady = 1'b1;
    for (int i = 0; i < 20 && (q.size() != 0 || qn.size() != 0); i++) step(a);
    chk("drain_empty", 64'(q.size() + qn.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n_acc, rdy_drop;
    reset = 1'b1; Flush = 1'b0; ReqValid = 1'b0; RspReady = 1'b0;
    VPN = '0; PPN = '0; HitPageType = '0; Napot = 1'b0; Offset = '0; TLBHit = 1'b0;
    pend = '0; pend_n = '0;

    vecs[0]  = mkv(36'h123456789, 44'hABCDE,     3'd0, 0, 1, 56'hABCDE345,    0, 0, 56'hABCDE345);
    vecs[1]  = mkv(36'h1F5,       44'h80000,     3'd1, 0, 1, 56'h801F5345,    0, 0, 56'h801F5345);
    vecs[2]  = mkv(36'h1F5,       44'h80001,     3'd1, 0, 1, 56'h801F5345,    0, 1, 56'h801F5345);
    vecs[3]  = mkv(36'h7A,        44'h12340,     3'd0, 1, 1, 56'h1234A345,    0, 0, 56'h12340345);
    vecs[4]  = mkv(36'h123456789, 44'hABCDE,     3'd0, 0, 0, 56'h0,           1, 0, 56'h0);
    vecs[5]  = mkv(36'h123456789, 44'hABCDE,     3'd5, 0, 1, 56'hABCDE345,    0, 1, 56'hABCDE345);
    vecs[6]  = mkv(36'h3FFFF,     44'hFFFC0000,  3'd2, 0, 1, 56'hFFFFFFFF345, 0, 0, 56'hFFFFFFFF345);
    vecs[7]  = mkv(36'h5555555,   44'h8000000,   3'd3, 0, 1, 56'hD555555345,  0, 0, 56'hD555555345);
    vecs[8]  = mkv(36'h1F5,       44'h80000,     3'd4, 0, 1, 56'h80000345,    0, 1, 56'h80000345);
    vecs[9]  = mkv(36'h1F5,       44'h80000,     3'd1, 1, 1, 56'h801F5345,    0, 0, 56'h801F5345);
    vecs[10] = mkv(36'h7A,        44'h12340,     3'd0, 1, 0, 56'h0,           1, 0, 56'h0);
    vecs[11] = mkv(36'h7A,        44'h12341,     3'd0, 1, 1, 56'h1234A345,    0, 1, 56'h12341345);

    @(negedge clk);
    step(acc);
    step(acc);
    reset = 1'b0;
    #1;
    chk("reset_reqready", 64'(ReqReady), 64'd1);
    chk("reset_rspvalid", 64'(RspValid), 64'd0);
    chk("reset_pa", 64'(TLBPAdr), 64'd0);
    chk("reset_miss", 64'(Miss), 64'd0);
    chk("reset_misaligned", 64'(Misaligned), 64'd0);

    // Directed vectors, one at a time, with latency check
    foreach (vecs[i]) begin
      VPN = vecs[i].vpn; PPN = vecs[i].ppn; HitPageType = vecs[i].t;
      Napot = vecs[i].napot; TLBHit = vecs[i].hit; Offset = 12'h345;
      pend   = '{pa: vecs[i].pa,    miss: vecs[i].miss, mis: vecs[i].mis};
      pend_n = '{pa: vecs[i].pa_nn, miss: vecs[i].miss, mis: 1'b0};
      ReqValid = 1'b1;
      RspReady = 1'b1;
      step(acc);
      chk("vec_accept", 64'(acc), 64'd1);
      ReqValid = 1'b0;
      k = 1;
      while (k <= 8) begin
        #1;
        if (RspValid) break;
        step(acc);
        k++;
      end
      chk("vec_latency", 64'(k), 64'd2);
      step(acc);
      chk("vec_consumed", 64'(q.size() + qn.size()), 64'd0);
    end

    // Backpressure: 4 back-to-back requests, consumer stalled for 4 cycles
    n_acc = 0;
    rdy_drop = -1;
    for (int c = 0; c < 30 && !(n_acc == 4 && q.size() == 0); c++) begin
      RspReady = (c >= 4);
      ReqValid = (n_acc < 4);
      drive_req(VB'(36'h100 + n_acc), PB'(44'hA000 + n_acc), 3'd0, 1'b0, 1'b1, 12'h345);
      #1;
      if (ReqValid && !ReqReady && rdy_drop < 0) rdy_drop = n_acc;
      step(acc);
      if (acc) n_acc++;
    end
    chk("bp_ready_fall_after", 64'(rdy_drop), 64'd2);
    chk("bp_accepted", 64'(n_acc), 64'd4);
    drain();

    // Flush with two in flight and a request pending
    RspReady = 1'b0;
    for (int j = 0; j < 2; j++) begin
      drive_req(VB'(36'h200 + j), PB'(44'h5000 + j), 3'd0, 1'b0, 1'b1, 12'h345);
      ReqValid = 1'b1;
      step(acc);
      chk("flush_fill_accept", 64'(acc), 64'd1);
    end
    drive_req(36'h2FF, 44'h5FFF, 3'd0, 1'b0, 1'b1, 12'h345);
    Flush = 1'b1;
    #1;
    chk("flush_reqready", 64'(ReqReady), 64'd0);
    step(acc);
    Flush = 1'b0;
    ReqValid = 1'b0;
    #1;
    chk("flush_rspvalid", 64'(RspValid), 64'd0);
    RspReady = 1'b1;
    for (int j = 0; j < 4; j++) step(acc);
    drive_req(36'h3AB, 44'h7777, 3'd1, 1'b0, 1'b1, 12'h345);
    ReqValid = 1'b1;
    step(acc);
    chk("post_flush_accept", 64'(acc), 64'd1);
    drain();

    // Reset mid-operation
    RspReady = 1'b0;
    for (int j = 0; j < 2; j++) begin
      drive_req(VB'(36'h400 + j), PB'(44'h6000 + j), 3'd0, 1'b0, 1'b1, 12'h345);
      ReqValid = 1'b1;
      step(acc);
    end
    reset = 1'b1;
    step(acc);
    reset = 1'b0;
    ReqValid = 1'b0;
    #1;
    chk("rst2_rspvalid", 64'(RspValid), 64'd0);
    chk("rst2_pa", 64'(TLBPAdr), 64'd0);
    chk("rst2_miss", 64'(Miss), 64'd0);
    chk("rst2_misaligned", 64'(Misaligned), 64'd0);
    chk("rst2_reqready", 64'(ReqReady), 64'd1);

    // Randomized traffic against the page model
    for (int c = 0; c < 400; c++) begin
      int t;
      logic [PB-1:0] p;
      t = $urandom_range(0, 5);
      p = PB'({$urandom, $urandom});
      if (($urandom % 2) == 0 && t < LV) p = (p >> (t * LB)) << (t * LB);
      drive_req(VB'({$urandom, $urandom}), p, 3'(t), 1'($urandom), (($urandom % 8) != 0),
                12'($urandom));
      ReqValid = (($urandom % 4) != 0);
      RspReady = (($urandom % 3) != 0);
      Flush    = (($urandom % 60) == 0);
      step(acc);
    end
    Flush = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
